// File: rtl/stage4_memory_pkg.sv
// Types and constants for the memory stage, shared with the neighbouring pipeline stages.
package stage4_memory_pkg;

  localparam int REGISTER_WIDTH = 32;
  localparam int BYTE_WIDTH     = 8;
  localparam int BE_WIDTH       = REGISTER_WIDTH / BYTE_WIDTH;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // funct3[1:0] gives the access size for both loads and stores
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
  } decoded_instruction_t;

  typedef struct packed {
    decoded_instruction_t              decoded_instruction;
    logic [REGISTER_WIDTH-1:0]         alu_result;
    logic [REGISTER_WIDTH-1:0]         rs2_data;
    logic [REGISTER_WIDTH-1:0]         branch_target;
  } execute_to_memory_t;

  typedef struct packed {
    decoded_instruction_t              decoded_instruction;
    logic [REGISTER_WIDTH-1:0]         alu_result;
    logic [REGISTER_WIDTH-1:0]         branch_target;
    logic [REGISTER_WIDTH-1:0]         data_from_memory;
  } memory_to_writeback_t;

  typedef enum logic {IDLE, ACCESS} mem_state_e;

endpackage

// File: rtl/stage4_memory_if.sv
// Stream channel between pipeline stages.
// A beat transfers on a rising clk edge with tvalid && tready; the master keeps
// tvalid high and tdata stable until that edge, and tvalid never depends on tready.
interface stage4_memory_if #(parameter type T = logic);
  logic tvalid;
  logic tready;
  T     tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/stage4_memory_store_lane_align.sv
// Places store data and byte enables on the addressed byte lane and flags
// accesses that would cross a word boundary.
module stage4_memory_store_lane_align
  import stage4_memory_pkg::*;
(
  input  logic [2:0]                funct3_i,
  input  logic [1:0]                offset_i,
  input  logic [REGISTER_WIDTH-1:0] rs2_i,
  output logic [BE_WIDTH-1:0]       be_o,
  output logic [REGISTER_WIDTH-1:0] wdata_o,
  output logic                      misaligned_o
);

  // Bit 2 only selects sign/zero extension, which is handled in writeback.
  logic unused_funct3_ext;
  assign unused_funct3_ext = funct3_i[2];

  always_comb begin
    be_o         = '0;
    misaligned_o = 1'b0;
    unique case (funct3_i[1:0])
      SIZE_BYTE: be_o = BE_WIDTH'(4'b0001) << offset_i;
      SIZE_HALF: begin
        be_o         = BE_WIDTH'(4'b0011) << offset_i;
        misaligned_o = (offset_i == 2'd3);
      end
      default: begin
        be_o         = '1;
        misaligned_o = (offset_i != 2'd0);
      end
    endcase
  end

  assign wdata_o = rs2_i << {offset_i, 3'b000};

endmodule

// File: rtl/stage4_memory.sv
// Pipeline stage 4: issues loads/stores on the req/ack data bus and registers
// the result beat for writeback.
module stage4_memory
  import stage4_memory_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  stage4_memory_if.slave             axis_execute_to_memory,
  stage4_memory_if.master            axis_memory_to_writeback,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [REGISTER_WIDTH-1:0]  dmem_wdata,
  output logic [BE_WIDTH-1:0]        dmem_be,
  input  logic [REGISTER_WIDTH-1:0]  dmem_rdata,
  input  logic                       dmem_ack,
  output logic                       misaligned_error,
  output logic                       bus_error,
  output mem_state_e                 dbg_state_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e                state_q, state_d;
  logic                      out_valid_q, out_valid_d;
  memory_to_writeback_t      out_data_q, out_data_d;
  decoded_instruction_t      pend_instr_q, pend_instr_d;
  logic [REGISTER_WIDTH-1:0] pend_alu_q, pend_alu_d;
  logic [REGISTER_WIDTH-1:0] pend_bt_q, pend_bt_d;
  logic                      req_q, req_d, we_q, we_d;
  logic [DMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REGISTER_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_WIDTH-1:0]       be_q, be_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      mis_err_q, mis_err_d, bus_err_q, bus_err_d;

  execute_to_memory_t        in_data;
  logic                      in_ready, in_fire, is_load, is_store, lane_misaligned;
  logic [BE_WIDTH-1:0]       lane_be;
  logic [REGISTER_WIDTH-1:0] lane_wdata, load_data;

  assign in_data  = axis_execute_to_memory.tdata;
  assign in_ready = (state_q == IDLE) && (!out_valid_q || axis_memory_to_writeback.tready);
  assign in_fire  = axis_execute_to_memory.tvalid && in_ready;
  assign is_load  = (in_data.decoded_instruction.opcode == OPCODE_LOAD);
  assign is_store = (in_data.decoded_instruction.opcode == OPCODE_STORE);
  assign load_data = dmem_rdata >> {pend_alu_q[1:0], 3'b000};

  stage4_memory_store_lane_align u_lane (
    .funct3_i     (in_data.decoded_instruction.funct3),
    .offset_i     (in_data.alu_result[1:0]),
    .rs2_i        (in_data.rs2_data),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .misaligned_o (lane_misaligned)
  );

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q && !axis_memory_to_writeback.tready;
    out_data_d   = out_data_q;
    pend_instr_d = pend_instr_q;
    pend_alu_d   = pend_alu_q;
    pend_bt_d    = pend_bt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    cnt_d        = cnt_q;
    mis_err_d    = mis_err_q;
    bus_err_d    = bus_err_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          if ((is_load || is_store) && !lane_misaligned) begin
            state_d      = ACCESS;
            pend_instr_d = in_data.decoded_instruction;
            pend_alu_d   = in_data.alu_result;
            pend_bt_d    = in_data.branch_target;
            req_d        = 1'b1;
            we_d         = is_store;
            addr_d       = {in_data.alu_result[DMEM_ADDR_WIDTH-1:2], 2'b00};
            wdata_d      = lane_wdata;
            be_d         = is_store ? lane_be : '0;
            cnt_d        = '0;
          end else begin
            // Plain ALU ops and misaligned accesses go straight to the output slot.
            out_valid_d = 1'b1;
            out_data_d  = '{decoded_instruction: in_data.decoded_instruction,
                            alu_result:          in_data.alu_result,
                            branch_target:       in_data.branch_target,
                            data_from_memory:    '0};
            if (is_load || is_store) mis_err_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        // The output slot is always empty here, so completing never overwrites a beat.
        if (dmem_ack || cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          out_data_d  = '{decoded_instruction: pend_instr_q,
                          alu_result:          pend_alu_q,
                          branch_target:       pend_bt_q,
                          data_from_memory:    (dmem_ack && !we_q) ? load_data : '0};
          req_d       = 1'b0;
          we_d        = 1'b0;
          be_d        = '0;
          if (!dmem_ack) bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      pend_instr_q <= '0;
      pend_alu_q   <= '0;
      pend_bt_q    <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      cnt_q        <= '0;
      mis_err_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      pend_instr_q <= pend_instr_d;
      pend_alu_q   <= pend_alu_d;
      pend_bt_q    <= pend_bt_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      cnt_q        <= cnt_d;
      mis_err_q    <= mis_err_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign axis_execute_to_memory.tready   = in_ready;
  assign axis_memory_to_writeback.tvalid = out_valid_q;
  assign axis_memory_to_writeback.tdata  = out_data_q;
  assign dmem_req         = req_q;
  assign dmem_we          = we_q;
  assign dmem_addr        = addr_q;
  assign dmem_wdata       = wdata_q;
  assign dmem_be          = be_q;
  assign misaligned_error = mis_err_q;
  assign bus_error        = bus_err_q;
  assign dbg_state_o      = state_q;

endmodule
